// File: rtl/cache_ctrl_if.sv
// Bundle of the CPU request port, cache-array port, memory port and
// performance counters seen by the cache sequencing controller.
interface cache_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ready;
  logic              cpu_stall;

  logic [ADDR_W-1:0] cache_addr;
  logic [DATA_W-1:0] cache_wdata;
  logic              cache_read_en;
  logic              cache_write_en;
  logic [DATA_W-1:0] cache_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  logic [CNT_W-1:0]  hit_cnt;
  logic [CNT_W-1:0]  miss_cnt;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cache_rdata, mem_rdata, mem_ready,
    input  cpu_rdata, cpu_ready, cpu_stall, cache_addr, cache_wdata, cache_read_en,
           cache_write_en, mem_req, mem_we, mem_addr, mem_wdata, hit_cnt, miss_cnt
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cache_rdata, mem_rdata, mem_ready,
    output cpu_rdata, cpu_ready, cpu_stall, cache_addr, cache_wdata, cache_read_en,
           cache_write_en, mem_req, mem_we, mem_addr, mem_wdata, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/cache_ctrl.sv
// Sequencing controller for a 32-line, 4-word direct-mapped write-through cache:
// tag/valid directory, hit/miss handling, word-by-word refill and counters.
module cache_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input logic         clk,
  input logic         rst,
  cache_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOOKUP, RD_WAIT, REFILL, WR_MEM, RESP} state_t;

  state_t            state;
  logic [1:0]        k;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [31:0]       valid;
  logic [2:0]        tag_q [32];

  logic [DATA_W-1:0] cpu_rdata_q;
  logic              cpu_ready_q;
  logic              cache_re_q;
  logic              cache_we_q;
  logic [ADDR_W-1:0] cache_addr_q;
  logic [DATA_W-1:0] cache_wdata_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [CNT_W-1:0]  hit_cnt_q;
  logic [CNT_W-1:0]  miss_cnt_q;

  logic [4:0] in_line, req_line;
  logic [2:0] in_tag, req_tag;
  logic       hit_in, hit_req, accept, refill_wr, fill_done;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign in_line   = bus.cpu_addr[6:2];
  assign in_tag    = bus.cpu_addr[9:7];
  assign req_line  = req_addr[6:2];
  assign req_tag   = req_addr[9:7];
  assign hit_in    = valid[in_line] && (tag_q[in_line] == in_tag);
  assign hit_req   = valid[req_line] && (tag_q[req_line] == req_tag);
  assign accept    = (state == IDLE) && bus.cpu_req;
  assign refill_wr = (state == REFILL) && bus.mem_ready;
  assign fill_done = refill_wr && (k == 2'd3);

  // Request latch and tag store hold data only; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (accept) begin
      req_we    <= bus.cpu_we;
      req_addr  <= bus.cpu_addr;
      req_wdata <= bus.cpu_wdata;
    end
    if (fill_done) tag_q[req_line] <= req_tag;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      k             <= 2'd0;
      valid         <= '0;
      cpu_rdata_q   <= '0;
      cpu_ready_q   <= 1'b0;
      cache_re_q    <= 1'b0;
      cache_we_q    <= 1'b0;
      cache_addr_q  <= '0;
      cache_wdata_q <= '0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      hit_cnt_q     <= '0;
      miss_cnt_q    <= '0;
    end else begin
      cpu_ready_q <= 1'b0;
      cache_re_q  <= 1'b0;
      cache_we_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cpu_req) begin
            state <= LOOKUP;
            // Directory is stable until a refill, so the hit seen here is the
            // one LOOKUP acts on; this lets the cache strobes be registered.
            if (hit_in) begin
              cache_re_q    <= !bus.cpu_we;
              cache_we_q    <= bus.cpu_we;
              cache_addr_q  <= bus.cpu_addr;
              cache_wdata_q <= bus.cpu_wdata;
            end
          end
        end
        LOOKUP: begin
          if (hit_req) hit_cnt_q  <= sat_inc(hit_cnt_q);
          else         miss_cnt_q <= sat_inc(miss_cnt_q);
          if (req_we) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= req_addr;
            mem_wdata_q <= req_wdata;
            state       <= WR_MEM;
          end else if (hit_req) begin
            state <= RD_WAIT;
          end else begin
            k          <= 2'd0;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= {req_addr[ADDR_W-1:2], 2'd0};
            state      <= REFILL;
          end
        end
        RD_WAIT: begin
          cpu_rdata_q <= bus.cache_rdata;
          cpu_ready_q <= 1'b1;
          state       <= RESP;
        end
        REFILL: begin
          if (bus.mem_ready) begin
            if (k == req_addr[1:0]) cpu_rdata_q <= bus.mem_rdata;
            if (k == 2'd3) begin
              valid[req_line] <= 1'b1;
              mem_req_q       <= 1'b0;
              cpu_ready_q     <= 1'b1;
              state           <= RESP;
            end else begin
              mem_addr_q <= {req_addr[ADDR_W-1:2], k + 2'd1};
            end
            k <= k + 2'd1;
          end
        end
        WR_MEM: begin
          if (bus.mem_ready) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            cpu_ready_q <= 1'b1;
            state       <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Refill words go straight into the array in the same cycle mem_ready arrives.
  assign bus.cache_write_en = cache_we_q | refill_wr;
  assign bus.cache_addr     = refill_wr ? mem_addr_q : cache_addr_q;
  assign bus.cache_wdata    = refill_wr ? bus.mem_rdata : cache_wdata_q;
  assign bus.cache_read_en  = cache_re_q;

  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.cpu_ready = cpu_ready_q;
  assign bus.cpu_stall = (state != IDLE);
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.hit_cnt   = hit_cnt_q;
  assign bus.miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed testbench for cache_ctrl with behavioural cache array and main memory.
module tb_cache_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  cache_ctrl_if #(.ADDR_W(10), .DATA_W(32), .CNT_W(16)) bus ();
  cache_ctrl #(.ADDR_W(10), .DATA_W(32), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Environment: cache array, main memory and event counters
  logic [31:0] carr [128];
  logic [31:0] mem_model [1024];
  bit [1023:0] mem_written;
  int          n_mrd = 0, n_mwr = 0, n_cwe = 0;
  logic [9:0]  rd_addrs [$];

  function automatic logic [31:0] dflt(input logic [9:0] a);
    return 32'hC0DE0000 | {22'd0, a};
  endfunction

  always @(posedge clk) begin
    if (bus.cache_write_en) begin
      carr[bus.cache_addr[6:0]] <= bus.cache_wdata;
      n_cwe++;
    end
    if (bus.cache_read_en) bus.cache_rdata <= carr[bus.cache_addr[6:0]];
    if (bus.mem_req && bus.mem_ready) begin
      if (bus.mem_we) begin
        mem_model[bus.mem_addr]   <= bus.mem_wdata;
        mem_written[bus.mem_addr] <= 1'b1;
        n_mwr++;
      end else begin
        n_mrd++;
        rd_addrs.push_back(bus.mem_addr);
      end
    end
  end

  // Memory answers in the first cycle of every word.
  always @(posedge clk) begin
    #1;
    bus.mem_ready = bus.mem_req;
    bus.mem_rdata = mem_written[bus.mem_addr] ? mem_model[bus.mem_addr] : dflt(bus.mem_addr);
  end

  task automatic issue(input logic we, input logic [9:0] addr, input logic [31:0] wdata,
                       input logic hold, output int rdy_cyc, output int re_cyc,
                       output int nreq, output logic [31:0] rdata);
    int cyc;
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    rdy_cyc = -1; re_cyc = -1; nreq = 0; cyc = 0; rdata = '0;
    while (rdy_cyc < 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.cache_read_en && re_cyc < 0) re_cyc = cyc;
      if (bus.mem_req) nreq++;
      if (bus.cpu_ready) begin
        rdy_cyc = cyc;
        rdata   = bus.cpu_rdata;
      end
      if (!hold || bus.cpu_ready) bus.cpu_req = 1'b0;
    end
    if (rdy_cyc < 0) begin
      checks++; errors++;
      $display("FAIL timeout addr=%0h: no cpu_ready within 40 cycles", addr);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req got %b want 0", bus.mem_req); end
    checks++; if (bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b want 0", bus.cpu_stall); end
    checks++; if (bus.cache_write_en !== 1'b0 || bus.cache_read_en !== 1'b0) begin errors++; $display("FAIL rst_cache_en got %b%b want 00", bus.cache_read_en, bus.cache_write_en); end
    checks++; if (bus.cpu_rdata !== 32'd0 || bus.cpu_ready !== 1'b0) begin errors++; $display("FAIL rst_cpu got %h/%b want 0/0", bus.cpu_rdata, bus.cpu_ready); end
    checks++; if (bus.hit_cnt !== 16'd0 || bus.miss_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt got %0d/%0d want 0/0", bus.hit_cnt, bus.miss_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_read_miss;
    int rc, re, nr, base; logic [31:0] rd;
    base = n_mrd;
    issue(1'b0, 10'h0A5, 32'd0, 1'b0, rc, re, nr, rd);
    checks++; if (rc !== 6) begin errors++; $display("FAIL miss_latency got %0d want 6", rc); end
    checks++; if (rd !== dflt(10'h0A5)) begin errors++; $display("FAIL miss_rdata got %h want %h", rd, dflt(10'h0A5)); end
    checks++; if (n_mrd - base !== 4) begin errors++; $display("FAIL miss_words got %0d want 4", n_mrd - base); end
    for (int i = 0; i < 4; i++) begin
      logic [9:0] ea;
      ea = 10'h0A4 + 10'(i);
      checks++; if (rd_addrs[base+i] !== ea) begin errors++; $display("FAIL miss_addr%0d got %h want %h", i, rd_addrs[base+i], ea); end
    end
    checks++; if (bus.miss_cnt !== 16'd1) begin errors++; $display("FAIL miss_cnt got %0d want 1", bus.miss_cnt); end
  endtask

  task automatic test_read_hit;
    int rc, re, nr; logic [31:0] rd;
    issue(1'b0, 10'h0A7, 32'd0, 1'b0, rc, re, nr, rd);
    checks++; if (re !== 1) begin errors++; $display("FAIL hit_read_en_cycle got %0d want 1", re); end
    checks++; if (rc !== 3) begin errors++; $display("FAIL hit_latency got %0d want 3", rc); end
    checks++; if (nr !== 0) begin errors++; $display("FAIL hit_mem_req got %0d want 0", nr); end
    checks++; if (rd !== dflt(10'h0A7)) begin errors++; $display("FAIL hit_rdata got %h want %h", rd, dflt(10'h0A7)); end
    checks++; if (bus.hit_cnt !== 16'd1) begin errors++; $display("FAIL hit_cnt got %0d want 1", bus.hit_cnt); end
  endtask

  task automatic test_write_hit;
    int rc, re, nr, cwe, mwr; logic [31:0] rd;
    cwe = n_cwe; mwr = n_mwr;
    issue(1'b1, 10'h0A6, 32'hDEADBEEF, 1'b0, rc, re, nr, rd);
    checks++; if (rc !== 3) begin errors++; $display("FAIL wr_latency got %0d want 3", rc); end
    checks++; if (n_cwe - cwe !== 1 || n_mwr - mwr !== 1) begin errors++; $display("FAIL wr_hit_writes got cache %0d mem %0d want 1 1", n_cwe - cwe, n_mwr - mwr); end
    checks++; if (bus.cpu_rdata !== dflt(10'h0A7)) begin errors++; $display("FAIL rdata_hold got %h want %h", bus.cpu_rdata, dflt(10'h0A7)); end
    issue(1'b0, 10'h0A6, 32'd0, 1'b0, rc, re, nr, rd);
    checks++; if (rd !== 32'hDEADBEEF || nr !== 0) begin errors++; $display("FAIL wr_hit_readback got %h req %0d want deadbeef req 0", rd, nr); end
    checks++; if (bus.hit_cnt !== 16'd3) begin errors++; $display("FAIL hit_cnt3 got %0d want 3", bus.hit_cnt); end
  endtask

  task automatic test_write_miss;
    int rc, re, nr, cwe, mwr, base; logic [31:0] rd;
    cwe = n_cwe; mwr = n_mwr;
    issue(1'b1, 10'h300, 32'h12345678, 1'b0, rc, re, nr, rd);
    checks++; if (n_cwe - cwe !== 0 || n_mwr - mwr !== 1) begin errors++; $display("FAIL wr_miss_writes got cache %0d mem %0d want 0 1", n_cwe - cwe, n_mwr - mwr); end
    base = n_mrd;
    issue(1'b0, 10'h300, 32'd0, 1'b0, rc, re, nr, rd);
    checks++; if (n_mrd - base !== 4 || rd !== 32'h12345678) begin errors++; $display("FAIL wr_miss_refill got words %0d data %h want 4 12345678", n_mrd - base, rd); end
    checks++; if (bus.miss_cnt !== 16'd3) begin errors++; $display("FAIL miss_cnt3 got %0d want 3", bus.miss_cnt); end
  endtask

  task automatic test_conflict;
    int rc, re, nr, base; logic [31:0] rd;
    base = n_mrd;
    issue(1'b0, 10'h1A4, 32'd0, 1'b0, rc, re, nr, rd);
    checks++; if (n_mrd - base !== 4 || rd !== dflt(10'h1A4)) begin errors++; $display("FAIL conflict_fill got words %0d data %h want 4 %h", n_mrd - base, rd, dflt(10'h1A4)); end
    base = n_mrd;
    issue(1'b0, 10'h0A4, 32'd0, 1'b0, rc, re, nr, rd);
    checks++; if (n_mrd - base !== 4 || rd !== dflt(10'h0A4)) begin errors++; $display("FAIL conflict_reread got words %0d data %h want 4 %h", n_mrd - base, rd, dflt(10'h0A4)); end
    checks++; if (bus.miss_cnt !== 16'd5) begin errors++; $display("FAIL miss_cnt5 got %0d want 5", bus.miss_cnt); end
  endtask

  task automatic test_req_held;
    int rc, re, nr; logic [31:0] rd;
    issue(1'b0, 10'h0A6, 32'd0, 1'b1, rc, re, nr, rd);
    repeat (3) @(negedge clk);
    checks++; if (rc !== 3 || bus.hit_cnt !== 16'd4) begin errors++; $display("FAIL req_held got lat %0d hits %0d want 3 4", rc, bus.hit_cnt); end
    checks++; if (bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL req_held_idle got stall %b want 0", bus.cpu_stall); end
  endtask

  task automatic test_reset_mid_refill;
    int rc, re, nr, base, cyc; logic [31:0] rd;
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 10'h055;
    base = n_mrd; cyc = 0;
    while (n_mrd - base < 2 && cyc < 20) begin
      @(negedge clk); cyc++; bus.cpu_req = 1'b0;
    end
    checks++; if (n_mrd - base !== 2) begin errors++; $display("FAIL midrst_words got %0d want 2", n_mrd - base); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.mem_req !== 1'b0 || bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL midrst_idle got req %b stall %b want 0 0", bus.mem_req, bus.cpu_stall); end
    checks++; if (bus.miss_cnt !== 16'd0 || bus.hit_cnt !== 16'd0) begin errors++; $display("FAIL midrst_cnt got %0d/%0d want 0/0", bus.hit_cnt, bus.miss_cnt); end
    rst = 1'b0;
    base = n_mrd;
    issue(1'b0, 10'h055, 32'd0, 1'b0, rc, re, nr, rd);
    checks++; if (n_mrd - base !== 4 || rc !== 6) begin errors++; $display("FAIL midrst_refill got words %0d lat %0d want 4 6", n_mrd - base, rc); end
    checks++; if (rd !== dflt(10'h055) || bus.miss_cnt !== 16'd1) begin errors++; $display("FAIL midrst_data got %h miss %0d want %h 1", rd, bus.miss_cnt, dflt(10'h055)); end
    base = n_mrd;
    issue(1'b0, 10'h0A7, 32'd0, 1'b0, rc, re, nr, rd);
    checks++; if (n_mrd - base !== 4 || rd !== dflt(10'h0A7)) begin errors++; $display("FAIL rst_invalidates got words %0d data %h want 4 %h", n_mrd - base, rd, dflt(10'h0A7)); end
  endtask

  task automatic test_back_to_back;
    int rc1, rc2, re, nr1, nr2; logic [31:0] rd1, rd2;
    issue(1'b0, 10'h056, 32'd0, 1'b0, rc1, re, nr1, rd1);
    issue(1'b0, 10'h054, 32'd0, 1'b0, rc2, re, nr2, rd2);
    checks++; if (rc1 !== 3 || rc2 !== 3 || nr1 !== 0 || nr2 !== 0) begin errors++; $display("FAIL b2b_lat got %0d %0d req %0d %0d want 3 3 0 0", rc1, rc2, nr1, nr2); end
    checks++; if (rd1 !== dflt(10'h056) || rd2 !== dflt(10'h054)) begin errors++; $display("FAIL b2b_data got %h %h want %h %h", rd1, rd2, dflt(10'h056), dflt(10'h054)); end
    checks++; if (bus.hit_cnt !== 16'd2) begin errors++; $display("FAIL b2b_hits got %0d want 2", bus.hit_cnt); end
  endtask

  initial begin
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    test_reset;
    test_read_miss;
    test_read_hit;
    test_write_hit;
    test_write_miss;
    test_conflict;
    test_req_held;
    test_reset_mid_refill;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
